// File: rtl/rf_pkg.sv
// rf_pkg: default register-file geometry and the hard-wired zero register address.
package rf_pkg;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_NUM_RD = 2;
   localparam int ZERO_REG   = 0;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending bits set on issue, cleared on writeback, with live pending count.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 iss_valid,
   input  logic [ADDR_W-1:0]    iss_wa,
   input  logic                 rf_we,
   input  logic [ADDR_W-1:0]    rf_wa,
   output logic [2**ADDR_W-1:0] pend,
   output logic [ADDR_W:0]      pend_cnt
);
   localparam int CW = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);
   logic set, clr;
   // count only real transitions so re-issue and duplicate writebacks never skew pend_cnt
   always_comb begin
      set = iss_valid && iss_wa != ZERO_A && !pend[iss_wa];
      clr = rf_we && rf_wa != ZERO_A && pend[rf_wa] && !(iss_valid && iss_wa == rf_wa);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pend     <= '0;
         pend_cnt <= '0;
      end else begin
         if (clr) pend[rf_wa] <= 1'b0;
         if (set) pend[iss_wa] <= 1'b1;
         pend_cnt <= pend_cnt + CW'(set) - CW'(clr);
      end
   end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read register file with scoreboard; define RF_BYPASS_EN to forward same-cycle writeback data.
module regfile_sb
   import rf_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = DEF_NUM_RD
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] rf_ra,
   output logic [NUM_RD*DATA_W-1:0] rf_rd,
   output logic [NUM_RD-1:0]        rf_busy,
   input  logic                     rf_we,
   input  logic [ADDR_W-1:0]        rf_wa,
   input  logic [DATA_W-1:0]        rf_wd,
   input  logic                     iss_valid,
   input  logic [ADDR_W-1:0]        iss_wa,
   output logic [ADDR_W:0]          pend_cnt,
   input  logic [ADDR_W-1:0]        debug_reg_ra,
   output logic [DATA_W-1:0]        debug_reg_rd
);
   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  pend;
   rf_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
      .clk       (clk),
      .rst       (rst),
      .iss_valid (iss_valid),
      .iss_wa    (iss_wa),
      .rf_we     (rf_we),
      .rf_wa     (rf_wa),
      .pend      (pend),
      .pend_cnt  (pend_cnt)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (rf_we && rf_wa != ZERO_A) begin
         mem[rf_wa] <= rf_wd;
      end
   end
   assign debug_reg_rd = mem[debug_reg_ra];
   genvar k;
   for (k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      assign ra = rf_ra[k*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
      logic hit;
      assign hit = rf_we && rf_wa == ra && ra != ZERO_A;
      assign rf_rd[k*DATA_W +: DATA_W] = hit ? rf_wd : mem[ra];
      assign rf_busy[k] = pend[ra] && !hit;
`else
      assign rf_rd[k*DATA_W +: DATA_W] = mem[ra];
      assign rf_busy[k] = pend[ra];
`endif
   end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning address width; depth = 2**ADDR_W.
REQ-003 The block SHALL have parameter NUM_RD, default 2, meaning number of read ports (1..4).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 system clock; rst input 1 synchronous active-high reset.
REQ-005 Port rf_ra: input, NUM_RD*ADDR_W; packed read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-006 Port rf_rd: output, NUM_RD*DATA_W; packed read data, same packing.
REQ-007 Port rf_busy: output, NUM_RD; per read port, addressed register has a pending write.
REQ-008 Port rf_we / rf_wa / rf_wd: input, 1 / ADDR_W / DATA_W; writeback enable, address, data.
REQ-009 Port iss_valid / iss_wa: input, 1 / ADDR_W; issue of an instruction that will write iss_wa (marks it pending).
REQ-010 Port pend_cnt: output, ADDR_W+1; number of registers currently pending.
REQ-011 Port debug_reg_ra: input, ADDR_W; debug_reg_rd: output, DATA_W; debug read, never bypassed.

Function
REQ-012 Reads SHALL be combinational: rf_rd[k] = reg[rf_ra[k]], 0-cycle latency.
REQ-013 Writes SHALL occur on posedge clk when rf_we=1 and rf_wa!=0; register 0 SHALL always read 0.
REQ-014 Pending bit p[a] SHALL set on posedge clk when iss_valid=1 and iss_wa=a, a!=0.
REQ-015 p[a] SHALL clear on posedge clk when rf_we=1 and rf_wa=a.
REQ-016 Set and clear of the same register in one cycle SHALL leave p[a]=1 (new producer wins).
REQ-017 Issue to a register already pending SHALL leave p[a]=1 with no error; writeback to a non-pending register SHALL still write data.
REQ-018 rf_busy[k] SHALL equal p[rf_ra[k]] (registered state, before same-cycle updates); address 0 SHALL never be busy.
REQ-019 pend_cnt SHALL equal the population count of p, updated the cycle after each set/clear; +1 and -1 in the same cycle on different registers SHALL net to 0.
REQ-020 pend_cnt SHALL never exceed 2**ADDR_W-1 and never underflow.

Reset
REQ-021 On rst=1 at posedge clk, all registers SHALL become 0, all p SHALL become 0, and pend_cnt SHALL become 0.
REQ-022 rst SHALL dominate rf_we and iss_valid in the same cycle; reset mid-operation discards in-flight writes.
REQ-023 After reset, every rf_rd, debug_reg_rd output SHALL be 0 and rf_busy SHALL be all 0.

Configuration
REQ-024 With RF_BYPASS_EN defined, rf_rd[k] SHALL return rf_wd and rf_busy[k] SHALL be 0 when rf_we=1, rf_wa=rf_ra[k]!=0 in the same cycle.
REQ-025 Without RF_BYPASS_EN, reads SHALL return the stored value only; new data is visible the cycle after the write.

Structure
REQ-026 Package rf_pkg SHALL hold default DATA_W/ADDR_W/NUM_RD constants and the zero-register address constant.
REQ-027 Pending-bit tracking and pend_cnt SHALL live in sub-module rf_scoreboard; storage and read muxing in regfile_sb.

Verification
REQ-028 rst pulse, then read all 32 addresses -> every rf_rd 0, rf_busy 0, pend_cnt 0.
REQ-029 iss_valid, iss_wa=5 -> next cycle rf_busy=1 for ra=5, pend_cnt=1; rf_we, wa=5, wd=0xDEADBEEF -> next cycle busy 0, rd=0xDEADBEEF, pend_cnt=0.
REQ-030 Write wa=0, wd=0x1234 plus issue iss_wa=0 -> rd(0)=0, busy 0, pend_cnt unchanged.
REQ-031 Same cycle issue wa=7 and writeback wa=7 (pending) -> p[7]=1, pend_cnt unchanged; issue wa=3 and writeback wa=7 -> pend_cnt unchanged net.
REQ-032 RF_BYPASS_EN: rf_we, wa=9, wd=0xA5A5A5A5, ra0=9 -> rf_rd0=0xA5A5A5A5 same cycle; without macro -> old value, new value next cycle; debug_reg_rd shows old value in both cases.
REQ-033 Issue wa=4 and wa=6, then rst with rf_we wa=4 wd=0x55 -> all registers 0, pend_cnt 0, reg4 stays 0.
